// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU instruction sequencer: opcodes, control sub-codes,
// FSM states and the 12-bit instruction layout {op, addr, data}.
package alu_seq_pkg;

  localparam int INSTR_W = 12;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CTRL = 2'b11;

  localparam logic [1:0] A_X   = 2'b00;
  localparam logic [1:0] A_Y   = 2'b01;
  localparam logic [1:0] A_NOP = 2'b10;

  localparam logic [1:0] CTRL_HALT = 2'b00;
  localparam logic [1:0] CTRL_WAIT = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} state_t;

  // Field order fixes the bit positions: op[11:10], addr[9:8], data[7:0]
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
  } instr_t;

  localparam instr_t NOP = '{op: OP_NONE, addr: A_NOP, data: 8'h00};

endpackage

// File: rtl/alu_seq_progmem.sv
// Program store: DEPTH x 12 words, one synchronous write port, one combinational read port.
// Contents are intentionally not reset so a program survives RST.
module alu_seq_progmem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Issues a loaded program onto the ALU OP/ADDR/DATA inputs, one word per cycle,
// with HALT/WAIT control words and PAUSE. Optional single-step: define ALU_SEQ_STEP_EN.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LD_EN,
  input  logic [AW-1:0]      LD_ADDR,
  input  logic [INSTR_W-1:0] LD_WORD,
  input  logic               START,
  input  logic               PAUSE,
`ifdef ALU_SEQ_STEP_EN
  input  logic               STEP,
  input  logic               STEP_MODE,
`endif
  output logic [1:0]         OP,
  output logic [1:0]         ADDR,
  output logic [7:0]         DATA,
  output logic [AW-1:0]      PC,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  state_t             st_q, st_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               end_q, end_d;  // wait in progress was issued from the last word
  instr_t             out_q, out_d;
  logic               err_q, err_d;
  logic [INSTR_W-1:0] rdata;
  instr_t             cur;
  logic               busy, advance, last;
  logic [AW-1:0]      pc_inc;

  assign busy   = (st_q == ST_RUN) || (st_q == ST_WAIT);
  assign cur    = instr_t'(rdata);
  assign last   = (pc_q == AW'(DEPTH-1));
  assign pc_inc = last ? pc_q : pc_q + AW'(1);

`ifdef ALU_SEQ_STEP_EN
  assign advance = !PAUSE && (!STEP_MODE || STEP);
`else
  assign advance = !PAUSE;
`endif

  alu_seq_progmem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (CLK),
    .we    (LD_EN && !busy),
    .waddr (LD_ADDR),
    .wdata (LD_WORD),
    .raddr (pc_q),
    .rdata (rdata)
  );

  always_comb begin
    st_d  = st_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    end_d = end_q;
    out_d = NOP;
    err_d = busy && (LD_EN || START);
    case (st_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          st_d  = ST_RUN;
          pc_d  = '0;
          cnt_d = '0;
          end_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (cur.op != OP_CTRL) begin
            out_d = cur;
            pc_d  = pc_inc;
            if (last) st_d = ST_DONE;
          end else if (cur.addr == CTRL_WAIT) begin
            cnt_d = cur.data;
            pc_d  = pc_inc;
            end_d = last;
            if (cur.data != 8'd0) st_d = ST_WAIT;
            else if (last)        st_d = ST_DONE;
          end else begin
            // HALT and the reserved 1x sub-codes stop here with PC held
            st_d = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (advance) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) st_d = end_q ? ST_DONE : ST_RUN;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q  <= ST_IDLE;
      pc_q  <= '0;
      cnt_q <= '0;
      end_q <= 1'b0;
      out_q <= NOP;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      end_q <= end_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign OP   = out_q.op;
  assign ADDR = out_q.addr;
  assign DATA = out_q.data;
  assign PC   = pc_q;
  assign BUSY = busy;
  assign DONE = (st_q == ST_DONE);
  assign ERR  = err_q;

endmodule
